dmem_vload_ctrl: RTL and testbench
==================================

DMEM_VLOAD_CTRL -- requirements
Module: dmem_vload_ctrl

Interface
REQ-001 Parameters: S, default 32, scalar word width; V, default 192, vector width; LANES, default V/S (6), words per vector; SIZE, default 30000, ROM depth in words.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  load request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_addr  input  S  word base address.
REQ-008 req_vector  input  1  1 = vector load (LANES words); 0 = scalar load (1 word).
REQ-009 resp_valid  output  1  resp_data/resp_err valid.
REQ-010 resp_ready  input  1  consumer accepts response.
REQ-011 resp_data  output  V  assembled result; lane k in bits [k*S +: S].
REQ-012 resp_err  output  1  at least one lane address was >= SIZE.
REQ-013 mem_addr  output  S  address to data ROM.
REQ-014 mem_isVector  output  1  ROM read enable; ROM returns data only when 1.
REQ-015 mem_rd  input  S  ROM read data; combinational from mem_addr in the same cycle.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, READ, RESP.
REQ-018 req_ready = 1 only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
REQ-019 On acceptance: latch req_addr into base, set lane count n = LANES (vector) or 1 (scalar), clear lane index and result register, clear err flag, go to READ.
REQ-020 In READ: mem_addr = base + lane index (modulo 2^S); mem_isVector = 1; at the edge, mem_rd is written to lane slot [idx]; idx increments by 1.
REQ-021 One lane is read per cycle; READ lasts exactly n cycles; after lane n-1 the FSM goes to RESP.
REQ-022 Lane address >= SIZE: mem_isVector = 0 for that cycle, slot written 0, err flag set; the remaining lanes still complete.
REQ-023 Scalar load: only lane 0 is written; bits [V-1:S] of resp_data are 0.
REQ-024 Outside READ: mem_isVector = 0, mem_addr = 0.
REQ-025 In RESP: resp_valid = 1, and resp_data and resp_err remain stable until resp_ready; on resp_valid & resp_ready, go to IDLE.
REQ-026 Latency: accept at edge 0; vector resp_valid is high from edge LANES+1 (7 cycles); scalar from edge 2.
REQ-027 No new request is accepted in the cycle the response completes; req_ready rises one cycle after the RESP to IDLE transition.
REQ-028 A request with base + LANES - 1 crossing 2^S wraps arithmetically; its lane addresses are checked against SIZE after the wrap.

Reset
REQ-029 rst takes priority over all inputs, including an in-flight READ or pending RESP; that operation is discarded with no response.
REQ-030 Reset values: state IDLE, req_ready 1 after reset releases, resp_valid 0, resp_data 0, resp_err 0, mem_addr 0, mem_isVector 0, busy 0.

Structure
REQ-031 A shared package dmem_pkg holds the state enum and the S, V, LANES and SIZE defaults.
REQ-032 The lane counter and lane-slot write-enable decoder form one sub-module, vload_lane_seq; the ROM stays outside this block.

Verification
REQ-033 ROM word[i] = i+0x100; vector req at addr 10; resp_ready=1 -> resp_valid at cycle 7, lanes 0..5 = 0x10A..0x10F, resp_err=0.
REQ-034 Scalar req at addr 3 -> resp_valid at cycle 2, resp_data = 0x103 zero-extended, resp_err=0.
REQ-035 Vector req at addr 29997 -> lanes 0..2 = ROM[29997..29999], lanes 3..5 = 0, resp_err=1, mem_isVector=0 in those 3 cycles.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_data stable, req_ready=0; new req_valid is held off until one cycle after the handshake.
REQ-037 Assert rst in the 3rd READ cycle -> next cycle IDLE with all outputs at reset values, no resp_valid; next request completes normally.
REQ-038 Back-to-back: hold req_valid continuously with alternating vector and scalar requests -> responses arrive in order with the correct lane counts.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the vector-load controller: default geometry, FSM
// state encoding and the lane-count helper.
package dmem_pkg;

  localparam int unsigned DefS     = 32;
  localparam int unsigned DefV     = 192;
  localparam int unsigned DefLanes = DefV / DefS;
  localparam int unsigned DefSize  = 30000;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp
  } vload_state_e;

  // Number of words fetched for one request.
  function automatic int unsigned lane_count(input logic is_vector, input int unsigned lanes);
    return is_vector ? lanes : 32'd1;
  endfunction

endpackage

// File: rtl/dmem_vload_ctrl_if.sv
// Request, response and ROM signals of the vector-load controller. The
// controller is the slave; the requester/ROM side is the master.
interface dmem_vload_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned S = DefS,
  parameter int unsigned V = DefV
);

  logic         req_valid;
  logic         req_ready;
  logic [S-1:0] req_addr;
  logic         req_vector;

  logic         resp_valid;
  logic         resp_ready;
  logic [V-1:0] resp_data;
  logic         resp_err;

  logic [S-1:0] mem_addr;
  logic         mem_isVector;
  logic [S-1:0] mem_rd;

  modport master (
    output req_valid, req_addr, req_vector, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_isVector
  );

  modport slave (
    input  req_valid, req_addr, req_vector, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_isVector
  );

endinterface

// File: rtl/vload_lane_seq.sv
// Lane sequencer: walks the lane index once per READ cycle and decodes it into
// a one-hot write enable for the result slots.
module vload_lane_seq
  import dmem_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned CntW  = $clog2(LANES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [CntW-1:0]  n,
  output logic [CntW-1:0]  idx,
  output logic             last,
  output logic [LANES-1:0] lane_we
);

  logic [CntW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (step) begin
      idx_q <= last ? '0 : idx_q + CntW'(1);
    end
  end

  assign idx  = idx_q;
  assign last = step && (idx_q == n - CntW'(1));

  always_comb begin
    lane_we = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_we[k] = step && (idx_q == CntW'(k));
    end
  end

endmodule

// File: rtl/dmem_vload_ctrl.sv
// Vector/scalar load controller: reads one ROM word per cycle into a lane
// register and returns the assembled result through a valid/ready response.
module dmem_vload_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned S     = DefS,
  parameter int unsigned V     = DefV,
  parameter int unsigned LANES = V / S,
  parameter int unsigned SIZE  = DefSize
) (
  input  logic                    clk,
  input  logic                    rst,
  dmem_vload_ctrl_if.slave        bus,
  output logic                    busy
);

  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam logic [S-1:0] SizeW = S'(SIZE);

  vload_state_e    state_q;
  logic [S-1:0]    base_q;
  logic [CntW-1:0] n_q;
  logic [V-1:0]    data_q;
  logic            err_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            busy_q;
  logic [S-1:0]    mem_addr_q;
  logic            mem_en_q;

  logic             accept;
  logic             step;
  logic [CntW-1:0]  lane_idx;
  logic             lane_last;
  logic [LANES-1:0] lane_we;
  logic [S-1:0]     next_addr;

  assign accept    = (state_q == StIdle) && bus.req_valid;
  assign step      = (state_q == StRead);
  // Address of the following lane; wraps modulo 2^S before the range check.
  assign next_addr = base_q + S'(lane_idx) + S'(1);

  vload_lane_seq #(
    .LANES (LANES),
    .CntW  (CntW)
  ) u_lane_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .step    (step),
    .n       (n_q),
    .idx     (lane_idx),
    .last    (lane_last),
    .lane_we (lane_we)
  );

  // mem_addr/mem_isVector are registered one lane ahead so they are valid for
  // the whole READ cycle that consumes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      n_q          <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_en_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q     <= StRead;
            base_q      <= bus.req_addr;
            n_q         <= CntW'(lane_count(bus.req_vector, LANES));
            data_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            mem_addr_q  <= bus.req_addr;
            mem_en_q    <= (bus.req_addr < SizeW);
          end
        end
        StRead: begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
              data_q[k*S +: S] <= mem_en_q ? bus.mem_rd : '0;
            end
          end
          if (!mem_en_q) begin
            err_q <= 1'b1;
          end
          if (lane_last) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_en_q     <= 1'b0;
          end else begin
            mem_addr_q <= next_addr;
            mem_en_q   <= (next_addr < SizeW);
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = data_q;
  assign bus.resp_err     = err_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_isVector = mem_en_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_dmem_vload_ctrl.sv
// Directed bench for dmem_vload_ctrl with a behavioural ROM (word[i] = i + 0x100).
module tb_dmem_vload_ctrl;

  logic clk;
  logic rst;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  dmem_vload_ctrl_if #(.S(32), .V(192)) bus ();

  dmem_vload_ctrl #(
    .S     (32),
    .V     (192),
    .LANES (6),
    .SIZE  (30000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  // ROM returns garbage when not enabled so unread slots must be zeroed by the DUT.
  assign bus.mem_rd = bus.mem_isVector ? bus.mem_addr + 32'h100 : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [191:0] DataV10 =
    {32'h10F, 32'h10E, 32'h10D, 32'h10C, 32'h10B, 32'h10A};
  localparam logic [191:0] DataV20 =
    {32'h119, 32'h118, 32'h117, 32'h116, 32'h115, 32'h114};
  localparam logic [191:0] DataEdge =
    {32'h0, 32'h0, 32'h0, 32'h762F, 32'h762E, 32'h762D};
  localparam logic [191:0] DataWrap =
    {32'h103, 32'h102, 32'h101, 32'h100, 32'h0, 32'h0};

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE. Latency counts negedges after presenting the
  // request; keep leaves req_valid high with the next request's fields.
  task automatic do_req(input string tag, input logic [31:0] addr, input logic vec,
                        input int exp_lat, input logic [191:0] exp_data, input logic exp_err,
                        input logic [5:0] exp_en, input int hold, input logic keep,
                        input logic [31:0] nxt_addr, input logic nxt_vec);
    int cyc;
    logic [5:0] en;
    check({tag, "/req_ready"}, 192'(bus.req_ready), 192'(1'b1));
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_vector = vec;
    cyc = 0;
    en  = '0;
    while (bus.resp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "/mem_addr0"}, 192'(bus.mem_addr), 192'(addr));
        if (keep) begin
          bus.req_addr   = nxt_addr;
          bus.req_vector = nxt_vec;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (cyc <= 6 && bus.resp_valid !== 1'b1) en[cyc-1] = bus.mem_isVector;
    end
    check({tag, "/latency"}, 192'(cyc), 192'(exp_lat));
    check({tag, "/data"}, bus.resp_data, exp_data);
    check({tag, "/err"}, 192'(bus.resp_err), 192'(exp_err));
    check({tag, "/en_mask"}, 192'(en), 192'(exp_en));
    check({tag, "/resp_mem"}, 192'({bus.mem_isVector, bus.mem_addr}), 192'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 192'(bus.resp_valid), 192'(1'b1));
      check({tag, "/hold_data"}, bus.resp_data, exp_data);
      check({tag, "/hold_ready"}, 192'({busy, bus.req_ready}), 192'(2'b10));
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "/post"}, 192'({bus.resp_valid, busy, bus.req_ready}), 192'(3'b001));
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_vector = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset/ready_busy", 192'({bus.req_ready, busy}), 192'(2'b10));
    check("reset/resp", 192'({bus.resp_valid, bus.resp_err}), 192'(0));
    check("reset/data", bus.resp_data, 192'(0));
    check("reset/mem", 192'({bus.mem_isVector, bus.mem_addr}), 192'(0));

    do_req("vec10", 32'd10, 1'b1, 7, DataV10, 1'b0, 6'h3F, 0, 1'b0, 32'd0, 1'b0);
    do_req("scal3", 32'd3, 1'b0, 2, 192'h103, 1'b0, 6'h01, 0, 1'b0, 32'd0, 1'b0);
    do_req("edge29997", 32'd29997, 1'b1, 7, DataEdge, 1'b1, 6'b000111, 0, 1'b0, 32'd0, 1'b0);
    do_req("wrap", 32'hFFFF_FFFE, 1'b1, 7, DataWrap, 1'b1, 6'b111100, 0, 1'b0, 32'd0, 1'b0);

    // Response held for 5 cycles while a scalar request waits.
    bus.resp_ready = 1'b0;
    do_req("hold", 32'd10, 1'b1, 7, DataV10, 1'b0, 6'h3F, 5, 1'b1, 32'd3, 1'b0);
    do_req("after_hold", 32'd3, 1'b0, 2, 192'h103, 1'b0, 6'h01, 0, 1'b0, 32'd0, 1'b0);

    // Reset during the third READ cycle drops the load.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'd10;
    bus.req_vector = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/ready_busy", 192'({bus.req_ready, busy}), 192'(2'b10));
    check("rst_mid/resp", 192'({bus.resp_valid, bus.resp_err}), 192'(0));
    check("rst_mid/data", bus.resp_data, 192'(0));
    check("rst_mid/mem", 192'({bus.mem_isVector, bus.mem_addr}), 192'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid/no_resp", 192'({bus.resp_valid, busy}), 192'(0));
    end
    do_req("rst_next", 32'd10, 1'b1, 7, DataV10, 1'b0, 6'h3F, 0, 1'b0, 32'd0, 1'b0);

    // Back-to-back with req_valid held high throughout.
    do_req("b2b0", 32'd10, 1'b1, 7, DataV10, 1'b0, 6'h3F, 0, 1'b1, 32'd3, 1'b0);
    do_req("b2b1", 32'd3, 1'b0, 2, 192'h103, 1'b0, 6'h01, 0, 1'b1, 32'd20, 1'b1);
    do_req("b2b2", 32'd20, 1'b1, 7, DataV20, 1'b0, 6'h3F, 0, 1'b1, 32'd29999, 1'b0);
    do_req("b2b3", 32'd29999, 1'b0, 2, 192'h762F, 1'b0, 6'h01, 0, 1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
